// File: rtl/claw_machine_param.sv
// Claw-machine credit controller: accumulates coin credit, converts it to claw
// strength on catch or to a payout on refund/overflow/idle timeout.
module claw_machine_param #(
  parameter int CW           = 4,
  parameter int MAX_CREDIT   = 9,
  parameter int COIN_A       = 1,
  parameter int COIN_B       = 2,
  parameter int TIMEOUT      = 255,
  parameter int CATCH_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          coin_a,
  input  logic          coin_b,
  input  logic          catch,
  input  logic          refund,
  output logic [CW-1:0] strength,
  output logic          strength_vld,
  output logic [CW-1:0] balance,
  output logic          balance_vld,
  output logic [CW-1:0] credit,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, CLAW} state_t;

  localparam int CCW = (CATCH_CYCLES > 1) ? $clog2(CATCH_CYCLES) : 1;
  localparam logic [CW:0]    VAL_A    = (CW+1)'(COIN_A);
  localparam logic [CW:0]    VAL_B    = (CW+1)'(COIN_B);
  localparam logic [CW:0]    MAX_SUM  = (CW+1)'(MAX_CREDIT);
  localparam logic [15:0]    TO_LAST  = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CCW-1:0] CLAW_LAST = CCW'(CATCH_CYCLES - 1);

  state_t         state;
  logic [15:0]    idle_cnt;
  logic [CCW-1:0] claw_cnt;

  logic [CW:0] dep;
  logic [CW:0] sum;
  logic        any_input;
  logic        timeout_hit;

  always_comb begin
    dep         = ({(CW+1){coin_a}} & VAL_A) + ({(CW+1){coin_b}} & VAL_B);
    sum         = {1'b0, credit} + dep;
    any_input   = coin_a | coin_b | catch | refund;
    timeout_hit = (TIMEOUT != 0) && !any_input && (idle_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      idle_cnt     <= '0;
      claw_cnt     <= '0;
      strength     <= '0;
      strength_vld <= 1'b0;
      balance      <= '0;
      balance_vld  <= 1'b0;
      credit       <= '0;
      busy         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every edge so each event yields exactly one
      // cycle of valid; any later assignment in this block overrides the default.
      strength     <= '0;
      strength_vld <= 1'b0;
      balance      <= '0;
      balance_vld  <= 1'b0;

      case (state)
        IDLE, CREDIT: begin
          if (dep != '0) begin
            idle_cnt <= '0;
            if (sum <= MAX_SUM) begin
              credit <= sum[CW-1:0];
              state  <= CREDIT;
            end else begin
              balance     <= sum[CW-1:0];
              balance_vld <= 1'b1;
              credit      <= '0;
              state       <= IDLE;
            end
          end else if (catch && !refund && credit != '0) begin
            strength     <= credit;
            strength_vld <= 1'b1;
            credit       <= '0;
            busy         <= 1'b1;
            claw_cnt     <= CLAW_LAST;
            idle_cnt     <= '0;
            state        <= CLAW;
          end else if ((refund && !catch && credit != '0) ||
                       (state == CREDIT && timeout_hit)) begin
            balance     <= credit;
            balance_vld <= 1'b1;
            credit      <= '0;
            idle_cnt    <= '0;
            state       <= IDLE;
          end else if (state == CREDIT) begin
            idle_cnt <= any_input ? '0 : idle_cnt + 16'd1;
          end
        end

        CLAW: begin
          // Coins while the claw runs are returned untouched.
          if (dep != '0) begin
            balance     <= dep[CW-1:0];
            balance_vld <= 1'b1;
          end
          if (claw_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            claw_cnt <= claw_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_claw_machine_param.sv
// Scoreboard bench for claw_machine_param: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever a valid strobe appears.
module tb_claw_machine_param;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          coin_a, coin_b, catch, refund;
  logic [CW-1:0] strength, balance, credit;
  logic          strength_vld, balance_vld, busy;

  typedef struct {
    bit is_strength;
    int value;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   fails   = 0;

  claw_machine_param #(
    .CW(CW), .MAX_CREDIT(9), .COIN_A(1), .COIN_B(2), .TIMEOUT(8), .CATCH_CYCLES(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .coin_a(coin_a), .coin_b(coin_b), .catch(catch), .refund(refund),
    .strength(strength), .strength_vld(strength_vld),
    .balance(balance), .balance_vld(balance_vld),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the given inputs across exactly one sampling edge.
  task automatic apply(input logic a, input logic b, input logic c, input logic r);
    coin_a = a; coin_b = b; catch = c; refund = r;
    tick();
    coin_a = 0; coin_b = 0; catch = 0; refund = 0;
  endtask

  task automatic expect_pulse(input bit is_s, input int v);
    exp_t e;
    e.is_strength = is_s;
    e.value       = v;
    exp_q.push_back(e);
  endtask

  task automatic count_busy(input int already, input string name, input int req);
    int n = already;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check(name, n, req);
  endtask

  // Monitor: every strobe must match the oldest expected pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (!strength_vld) check("strength_zero_when_invalid", int'(strength), 0);
        if (!balance_vld)  check("balance_zero_when_invalid", int'(balance), 0);
        if (strength_vld || balance_vld) begin
          check("vld_exclusive", int'(strength_vld & balance_vld), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind_is_strength", int'(strength_vld), int'(e.is_strength));
            check(e.is_strength ? "strength_value" : "balance_value",
                  e.is_strength ? int'(strength) : int'(balance), e.value);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rstn = 0; coin_a = 0; coin_b = 0; catch = 0; refund = 0;
    #12;
    check("reset_credit", int'(credit), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_vlds", int'(strength_vld | balance_vld), 0);
    @(negedge clk);
    rstn = 1;
    tick();

    // 1: build credit 2,4,6,7 then catch; busy lasts 4 cycles.
    apply(0, 1, 0, 0); check("t1_credit_2", int'(credit), 2);
    apply(0, 1, 0, 0); check("t1_credit_4", int'(credit), 4);
    apply(0, 1, 0, 0); check("t1_credit_6", int'(credit), 6);
    apply(1, 0, 0, 0); check("t1_credit_7", int'(credit), 7);
    expect_pulse(1, 7);
    apply(0, 0, 1, 0);
    check("t1_busy_on_catch", int'(busy), 1);
    check("t1_credit_cleared", int'(credit), 0);
    count_busy(0, "t1_busy_cycles", 4);
    check("t1_credit_after", int'(credit), 0);

    // 2: overflow deposit refunds everything.
    repeat (4) apply(0, 1, 0, 0);
    check("t2_credit_8", int'(credit), 8);
    expect_pulse(0, 11);
    apply(1, 1, 0, 0);
    check("t2_credit_0", int'(credit), 0);
    check("t2_not_busy", int'(busy), 0);
    apply(1, 0, 0, 0); check("t2_idle_accepts_coin", int'(credit), 1);
    expect_pulse(0, 1);
    apply(0, 0, 0, 1); check("t2_refund_clears", int'(credit), 0);

    // 3: simultaneous catch+refund is ignored, then a plain refund.
    apply(0, 1, 0, 0); apply(0, 1, 0, 0); apply(1, 0, 0, 0);
    check("t3_credit_5", int'(credit), 5);
    apply(0, 0, 1, 1);
    check("t3_both_ignored", int'(credit), 5);
    check("t3_both_not_busy", int'(busy), 0);
    expect_pulse(0, 5);
    apply(0, 0, 0, 1);
    check("t3_refund_credit_0", int'(credit), 0);

    // 4: idle timeout at the 8th input-free edge, restarted by a coin.
    apply(0, 1, 0, 0);
    repeat (7) tick();
    check("t4_held_7_idle", int'(credit), 2);
    expect_pulse(0, 2);
    tick();
    check("t4_timeout_refund", int'(credit), 0);
    apply(0, 1, 0, 0);
    repeat (4) tick();
    apply(1, 0, 0, 0);
    check("t4_credit_3", int'(credit), 3);
    repeat (7) tick();
    check("t4_held_after_restart", int'(credit), 3);
    expect_pulse(0, 3);
    tick();
    check("t4_second_timeout", int'(credit), 0);

    // 5: coin during the claw phase bounces without stretching busy.
    apply(1, 0, 0, 0);
    expect_pulse(1, 1);
    apply(0, 0, 1, 0);
    tick();
    expect_pulse(0, 2);
    apply(0, 1, 0, 0);
    check("t5_credit_stays_0", int'(credit), 0);
    check("t5_still_busy", int'(busy), 1);
    count_busy(2, "t5_busy_cycles", 4);
    apply(0, 0, 0, 1);
    check("t5_refund_ignored_idle", int'(credit), 0);

    // 6: asynchronous reset in the middle of the claw phase.
    apply(1, 0, 0, 0);
    expect_pulse(1, 1);
    apply(0, 0, 1, 0);
    tick();
    #2 rstn = 0;
    #1;
    check("t6_busy_async_clear", int'(busy), 0);
    check("t6_credit_async_clear", int'(credit), 0);
    check("t6_outputs_async_clear",
          int'(strength) + int'(balance) + int'(strength_vld) + int'(balance_vld), 0);
    @(negedge clk);
    rstn = 1;
    tick();
    check("t6_idle_after_reset", int'(busy), 0);
    apply(1, 0, 0, 0);
    check("t6_credit_1", int'(credit), 1);
    expect_pulse(0, 1);
    apply(0, 0, 0, 1);

    repeat (3) tick();
    check("all_pulses_seen", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
